// File: rtl/qpu_exu_tevt_queue.sv
// Timed-event queue: FIFO of event words, each released when the free-running timeline reaches its tag.
// Optional QPU_TEVT_LATE_CNT_EN adds a saturating 16-bit count of late pushes on port late_cnt.
module qpu_exu_tevt_queue #(
    parameter int TIME_W = 32,
    parameter int EVT_W  = 66,
    parameter int OPR_W  = 8,
    parameter int DEPTH  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_valid,
    output logic              i_ready,
    input  logic              i_ntp,
    input  logic [TIME_W-1:0] i_time,
    input  logic [EVT_W-1:0]  i_edata,
    input  logic [OPR_W-1:0]  i_oprand,
    output logic              o_valid,
    input  logic              o_ready,
    output logic [EVT_W-1:0]  o_edata,
    output logic [OPR_W-1:0]  o_oprand,
    output logic [TIME_W-1:0] o_tag,
    input  logic              run,
    input  logic              flush,
    output logic [TIME_W-1:0] cur_time,
    output logic              o_late,
    output logic              empty,
`ifdef QPU_TEVT_LATE_CNT_EN
    output logic [15:0]       late_cnt,
`endif
    output logic              full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [EVT_W-1:0]  mem_edata [DEPTH];
    logic [OPR_W-1:0]  mem_oprand[DEPTH];
    logic [TIME_W-1:0] mem_tag   [DEPTH];

    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  count;
    logic [TIME_W-1:0] tp;

    logic [TIME_W-1:0] head_tag;
    logic [TIME_W-1:0] due_diff;
    logic [TIME_W-1:0] push_tag;
    logic [TIME_W-1:0] late_diff;
    logic              push;
    logic              pop;
    logic              push_late;

    // NOTE: every signal assigned here gets a value on every path, so no latch is inferred.
    always_comb begin
        empty     = (count == '0);
        full      = (count == CNT_W'(DEPTH));
        i_ready   = !full;
        head_tag  = mem_tag[rd_ptr];
        // Wrap-aware compare: head is due once the timeline is at or past its tag.
        due_diff  = cur_time - head_tag;
        o_valid   = !empty && !due_diff[TIME_W-1];
        o_edata   = empty ? '0 : mem_edata[rd_ptr];
        o_oprand  = empty ? '0 : mem_oprand[rd_ptr];
        o_tag     = empty ? '0 : head_tag;
        push      = i_valid && i_ready && !flush;
        pop       = o_valid && o_ready && !flush;
        push_tag  = i_ntp ? (tp + i_time) : tp;
        late_diff = push_tag - cur_time;
        push_late = push && late_diff[TIME_W-1];
    end

    always_ff @(posedge clk) begin
        if (rst) cur_time <= '0;
        else if (run) cur_time <= cur_time + TIME_W'(1);
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            tp     <= '0;
            o_late <= 1'b0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            tp     <= cur_time;
            o_late <= 1'b0;
        end else begin
            o_late <= push_late;
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
                tp     <= push_tag;
            end
            if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: entry storage is not reset; count/empty gate every read, so stale words never leak out.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_edata[wr_ptr]  <= i_edata;
            mem_oprand[wr_ptr] <= i_oprand;
            mem_tag[wr_ptr]    <= push_tag;
        end
    end

`ifdef QPU_TEVT_LATE_CNT_EN
    always_ff @(posedge clk) begin
        if (rst || flush) late_cnt <= '0;
        else if (push_late && (late_cnt != 16'hFFFF)) late_cnt <= late_cnt + 16'd1;
    end
`endif

endmodule

// File: doc/qpu_exu_tevt_queue.md
Name: qpu_exu_tevt_queue

Overview:
Parametrised timed-event queue that sits behind the QPU ALU time/event write-back path (twbck/ewbck).
- Accepts event words (edata + oprand) tagged with a timepoint built from QWAIT/new-timepoint increments.
- Buffers them in a DEPTH-entry FIFO and releases each to the event register file when the free-running timeline counter reaches its tag.
- Replaces the untimed direct ewbck path; adds configurable depth, widths, late detection and flush.

Parameters:
TIME_W, 32, timepoint/timeline width (matches QPU_TIME_WIDTH)
EVT_W, 66, event data width (matches QPU_EVENT_WIRE_WIDTH)
OPR_W, 8, event operand mask width (matches QPU_EVENT_NUM)
DEPTH, 8, queue entries; power of two, 2..64

Ports:
clk  in  1  single clock
rst  in  1  synchronous reset, active-high
i_valid  in  1  push request
i_ready  out  1  push accept (= !full)
i_ntp  in  1  entry opens a new timepoint
i_time  in  TIME_W  timepoint increment (valid when i_ntp)
i_edata  in  EVT_W  event data
i_oprand  in  OPR_W  event operand mask
o_valid  out  1  head entry due
o_ready  in  1  event register file accepts
o_edata  out  EVT_W  head event data
o_oprand  out  OPR_W  head operand mask
o_tag  out  TIME_W  head timepoint tag
run  in  1  timeline counter enable
flush  in  1  discard all entries, rewind timepoint to timeline
cur_time  out  TIME_W  timeline counter
o_late  out  1  one-cycle pulse: pushed tag already in the past
empty  out  1  queue empty
full  out  1  queue full

Behaviour:
- Reset: cur_time=0, tp (timepoint reg)=0, rd/wr pointers=0, count=0. Outputs: empty=1, full=0, i_ready=1, o_valid=0, o_late=0, o_edata/o_oprand/o_tag=0.
- Timeline: cur_time increments by 1 each cycle run=1; wraps 2^TIME_W-1 -> 0.
- Tag on push (i_valid & i_ready):
  - i_ntp=1: tag = tp + i_time (mod 2^TIME_W); tp <= tag.
  - i_ntp=0: tag = tp.
- Due test is wrap-aware: due = MSB of (cur_time - head_tag) == 0. Tags must lie within 2^(TIME_W-1) of cur_time.
- Late: at push, if MSB of (tag - cur_time) == 1, o_late=1 next cycle. Entry still queued and issues as soon as it reaches head.
- Latency: pushed entry is visible at head no earlier than the cycle after push; no same-cycle bypass.
- o_valid = !empty & due(head); outputs driven from head entry storage. Head fields are 0 when empty.
- Pop on o_valid & o_ready: rd pointer advances, count decrements.
- Push and pop in the same cycle: both take effect, count unchanged.
- i_ready = !full, so a push is refused when full even if a pop occurs that cycle.
- Pointers are log2(DEPTH) bits and wrap naturally. full = (count==DEPTH); empty = (count==0).
- Events with equal tags issue one per cycle in push order (strict FIFO; no reordering).
- Flush (priority below rst, above push/pop):
  - Pointers and count cleared; tp <= cur_time.
  - Push and pop in the flush cycle are ignored. o_late not asserted.
  - cur_time continues counting.
- Reset mid-operation discards all entries and zeroes the timeline.

Optional Feature:
QPU_TEVT_LATE_CNT_EN
- Defined: adds output late_cnt (16 bits, saturating at 0xFFFF). Increments on each late push, clears on rst and flush.
- Undefined: port and counter absent; o_late pulse unchanged.

Test Plan:
- Timed release: rst, run=1 at cur_time=0; push ntp time=10 ev A -> o_valid rises exactly when cur_time=10, o_edata=A, o_tag=10.
- Same timepoint: push A (ntp, time=5), B (ntp=0), C (ntp, time=3) -> A,B issue at cur_time 5 and 6 (one per cycle), C at tag 8.
- Full/backpressure, DEPTH=8: push 8 with run=0 -> full=1, i_ready=0, 9th held. Pop one -> i_ready=1 next cycle, count stays 8 after refill.
- Late and wrap, TIME_W=8: cur_time=250; push tag 4 (tp=250, time=10) -> issues at cur_time 4 after wrap, no late. Push tag 240 -> o_late pulse, issues immediately.
- Flush: 5 queued entries, flush at cur_time=40 -> empty=1 next cycle, o_valid=0. Next push ntp time=2 gets tag 42.
- Reset mid-run: rst with 3 entries queued -> empty=1, cur_time=0, all outputs at reset values the following cycle.
